// File: rtl/perceptron_bram_sequencer.sv
// perceptron_bram_sequencer: reads N operand words from BRAM, waits DRAIN_CYCLES, enables perceptron for COMPUTE_CYCLES, writes {fire,perceptron_out} to START_ADDR+N; ports clk/rst/start in, bram_addr/bram_data_addr/bram_we/bram_wdata out, perceptron_out/fire in, perceptron_enable/busy/done out
module perceptron_bram_sequencer #(
  parameter int N = 8,
  parameter logic [8:0] START_ADDR = 9'd0,
  parameter int DRAIN_CYCLES = 2,
  parameter int COMPUTE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [8:0]  bram_addr,
  output logic [8:0]  bram_data_addr,
  output logic        bram_we,
  output logic [31:0] bram_wdata,
  input  logic [15:0] perceptron_out,
  input  logic        fire,
  output logic        perceptron_enable,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, COMPUTE, WRITE, DONE} state_t;
  localparam logic [8:0] WR_ADDR = 9'(START_ADDR + N);
  state_t state, state_nx;
  logic [31:0] cnt, lim;
  logic last;
  always_comb begin
    lim = state == LOAD ? 32'(N - 1) : state == DRAIN ? 32'(DRAIN_CYCLES - 1) : 32'(COMPUTE_CYCLES - 1);
    last = cnt == lim;
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? LOAD : IDLE;
      LOAD:    state_nx = last ? (DRAIN_CYCLES == 0 ? COMPUTE : DRAIN) : LOAD;
      DRAIN:   state_nx = last ? COMPUTE : DRAIN;
      COMPUTE: state_nx = last ? WRITE : COMPUTE;
      WRITE:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    bram_we = state == WRITE;
    perceptron_enable = state == COMPUTE;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bram_addr <= '0;
      bram_data_addr <= '0;
      bram_wdata <= '0;
    end else begin
      state <= state_nx;
      cnt <= state_nx != state ? '0 : cnt + 32'd1;
      bram_data_addr <= bram_addr;
      if (state == IDLE && start) bram_addr <= START_ADDR;
      else if (state == LOAD && !last) bram_addr <= bram_addr + 9'd1;
      else if (state == COMPUTE && last) bram_addr <= WR_ADDR;
      if (state == COMPUTE && last) bram_wdata <= {15'b0, fire, perceptron_out};
    end
  end
endmodule

// File: tb/tb_perceptron_bram_sequencer.sv
// tb_perceptron_bram_sequencer: directed self-checking bench for perceptron_bram_sequencer
module tb_perceptron_bram_sequencer;
  logic clk = 0, rst, start0, start1, fire, sel;
  logic [15:0] po;
  logic [8:0] addr0, addr1, daddr0, daddr1, m_addr, m_daddr;
  logic [31:0] wdata0, wdata1, m_wdata;
  logic we0, we1, en0, en1, busy0, busy1, done0, done1, m_we, m_en, m_busy, m_done;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  perceptron_bram_sequencer dut (
    .clk(clk), .rst(rst), .start(start0), .bram_addr(addr0), .bram_data_addr(daddr0),
    .bram_we(we0), .bram_wdata(wdata0), .perceptron_out(po), .fire(fire),
    .perceptron_enable(en0), .busy(busy0), .done(done0)
  );
  perceptron_bram_sequencer #(.N(8), .START_ADDR(9'h1FC), .DRAIN_CYCLES(0), .COMPUTE_CYCLES(4)) dut_w (
    .clk(clk), .rst(rst), .start(start1), .bram_addr(addr1), .bram_data_addr(daddr1),
    .bram_we(we1), .bram_wdata(wdata1), .perceptron_out(po), .fire(fire),
    .perceptron_enable(en1), .busy(busy1), .done(done1)
  );
  always_comb begin
    m_addr = sel ? addr1 : addr0;
    m_daddr = sel ? daddr1 : daddr0;
    m_wdata = sel ? wdata1 : wdata0;
    m_we = sel ? we1 : we0;
    m_en = sel ? en1 : en0;
    m_busy = sel ? busy1 : busy0;
    m_done = sel ? done1 : done0;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else start0 = v;
  endtask
  function automatic logic [8:0] exp_addr(input logic [8:0] sa, input int dc, input int k);
    return k < 8 ? sa + 9'(k) : (k < 12 + dc ? sa + 9'd7 : sa + 9'd8);
  endfunction
  task automatic test_reset();
    compared++;
    if ({addr0, daddr0, we0, wdata0, en0, busy0, done0} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got addr=%h daddr=%h we=%b wdata=%h en=%b busy=%b done=%b, want all 0",
               addr0, daddr0, we0, wdata0, en0, busy0, done0);
    end
  endtask
  task automatic run_pass(input string name, input logic s, input logic [8:0] sa, input int dc,
                          input logic [15:0] v, input logic f, input logic ign);
    int lat, dones;
    logic [31:0] ew;
    lat = 8 + dc + 4 + 2;
    dones = 0;
    ew = {15'b0, f, v};
    sel = s;
    po = v;
    fire = f;
    set_start(1);
    tick();
    set_start(0);
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) tick();
      compared++;
      if (m_addr !== exp_addr(sa, dc, k)) begin
        mismatched++;
        $display("FAIL %s addr k=%0d: got %h want %h", name, k, m_addr, exp_addr(sa, dc, k));
      end
      if (k > 0) begin
        compared++;
        if (m_daddr !== exp_addr(sa, dc, k - 1)) begin
          mismatched++;
          $display("FAIL %s data_addr k=%0d: got %h want %h", name, k, m_daddr, exp_addr(sa, dc, k - 1));
        end
      end
      compared++;
      if ({m_en, m_we, m_done, m_busy} !== {k >= 8 + dc && k < 12 + dc, k == lat - 2, k == lat - 1, k < lat}) begin
        mismatched++;
        $display("FAIL %s ctrl k=%0d: got en/we/done/busy=%b%b%b%b want %b%b%b%b", name, k, m_en, m_we, m_done, m_busy,
                 k >= 8 + dc && k < 12 + dc, k == lat - 2, k == lat - 1, k < lat);
      end
      if (k == lat - 2) begin
        po = ~v;
        fire = ~f;
        #1;
        compared++;
        if (m_wdata !== ew) begin
          mismatched++;
          $display("FAIL %s wdata: got %h want %h", name, m_wdata, ew);
        end
      end
      if (m_done) dones++;
      set_start(ign && (k == 3 || k == 10));
    end
    set_start(0);
    compared++;
    if (dones != 1) begin
      mismatched++;
      $display("FAIL %s done_count: got %0d want 1", name, dones);
    end
    if (ign)
      for (int c = 0; c < 20; c++) begin
        tick();
        compared++;
        if (m_busy !== 1'b0 || m_done !== 1'b0) begin
          mismatched++;
          $display("FAIL %s queued_start c=%0d: got busy=%b done=%b want 0 0", name, c, m_busy, m_done);
        end
      end
  endtask
  task automatic test_abort();
    sel = 0;
    po = 16'h5555;
    fire = 1;
    start0 = 1;
    tick();
    start0 = 0;
    for (int k = 1; k <= 12; k++) tick();
    compared++;
    if (en0 !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_precondition: got en=%b want 1", en0);
    end
    #3 rst = 1;
    #1;
    compared++;
    if ({addr0, daddr0, we0, wdata0, en0, busy0, done0} !== '0) begin
      mismatched++;
      $display("FAIL abort_async: got addr=%h daddr=%h we=%b wdata=%h en=%b busy=%b done=%b, want all 0",
               addr0, daddr0, we0, wdata0, en0, busy0, done0);
    end
    tick();
    rst = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      compared++;
      if (we0 !== 1'b0 || done0 !== 1'b0 || busy0 !== 1'b0) begin
        mismatched++;
        $display("FAIL abort_after c=%0d: got we=%b done=%b busy=%b want 0 0 0", c, we0, done0, busy0);
      end
    end
  endtask
  task automatic test_back_to_back();
    int dones, n;
    dones = 0;
    sel = 0;
    start0 = 1;
    tick();
    for (int c = 0; c < 40; c++) begin
      if (c > 0) tick();
      compared++;
      if (busy0 !== !(c == 16 || c == 33) || done0 !== (c == 15 || c == 32)) begin
        mismatched++;
        $display("FAIL b2b c=%0d: got busy=%b done=%b want %b %b", c, busy0, done0, !(c == 16 || c == 33), c == 15 || c == 32);
      end
      if (c <= 33 && done0) dones++;
    end
    start0 = 0;
    compared++;
    if (dones != 2) begin
      mismatched++;
      $display("FAIL b2b done_count: got %0d want 2", dones);
    end
    n = 0;
    while (busy0 && n < 40) begin
      tick();
      n++;
    end
    compared++;
    if (busy0 !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b drain_timeout: busy still %b after %0d cycles, want 0", busy0, n);
    end
  endtask
  initial begin
    rst = 1;
    start0 = 0;
    start1 = 0;
    po = 0;
    fire = 0;
    sel = 0;
    #1;
    test_reset();
    tick();
    rst = 0;
    tick();
    run_pass("basic", 0, 9'd0, 2, 16'h1234, 1, 0);
    run_pass("fire0", 0, 9'd0, 2, 16'hBEEF, 0, 0);
    run_pass("wrap", 1, 9'h1FC, 0, 16'h00A5, 1, 0);
    run_pass("ignore_start", 0, 9'd0, 2, 16'h0F0F, 1, 1);
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/perceptron_bram_sequencer.md
PERCEPTRON_BRAM_SEQUENCER -- requirements
Module: perceptron_bram_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of (x,w) operand words per pass.
REQ-002 The block SHALL have parameter START_ADDR, default 9'd0, giving the first operand address in BRAM.
REQ-003 The block SHALL have parameter DRAIN_CYCLES, default 2, giving the wait after the last read before compute.
REQ-004 The block SHALL have parameter COMPUTE_CYCLES, default 4, giving the number of cycles perceptron_enable is held high.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-007 The block SHALL have port start, input, 1, a pass request sampled in IDLE.
REQ-008 The block SHALL have port bram_addr, output, 9, the BRAM read/write address.
REQ-009 The block SHALL have port bram_data_addr, output, 9, bram_addr registered one cycle to tag returning BRAM read data.
REQ-010 The block SHALL have port bram_we, output, 1, the BRAM write strobe.
REQ-011 The block SHALL have port bram_wdata, output, 32, the result word written to BRAM.
REQ-012 The block SHALL have port perceptron_out, input, 16, the perceptron result.
REQ-013 The block SHALL have port fire, input, 1, the perceptron fire flag.
REQ-014 The block SHALL have port perceptron_enable, output, 1, the compute enable to the perceptron.
REQ-015 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 The block SHALL have port done, output, 1, a one-cycle pulse at pass end.

Function
REQ-017 The block SHALL implement states IDLE, LOAD, DRAIN, COMPUTE, WRITE, DONE.
REQ-018 In IDLE with start=1, the block SHALL enter LOAD next cycle with bram_addr=START_ADDR; in IDLE with start=0, it SHALL remain in IDLE.
REQ-019 LOAD SHALL last exactly N cycles, presenting bram_addr = START_ADDR, START_ADDR+1, ..., START_ADDR+N-1, one per cycle.
REQ-020 Address arithmetic SHALL be 9-bit modulo 512, so START_ADDR+k wraps past 9'h1FF to 9'h000.
REQ-021 DRAIN SHALL last DRAIN_CYCLES cycles, with bram_addr held at its last LOAD value.
REQ-022 COMPUTE SHALL last COMPUTE_CYCLES cycles, with perceptron_enable=1; perceptron_enable SHALL be 0 in all other states.
REQ-023 WRITE SHALL last one cycle: bram_we=1, bram_addr=START_ADDR+N (mod 512), bram_wdata={15'b0, fire, perceptron_out}, using the values sampled at the last COMPUTE edge.
REQ-024 bram_we SHALL be 0 in every state except WRITE.
REQ-025 DONE SHALL last one cycle with done=1, then the block SHALL return to IDLE.
REQ-026 Pass latency SHALL be N+DRAIN_CYCLES+COMPUTE_CYCLES+2 cycles from the first LOAD cycle to the done pulse inclusive.
REQ-027 start asserted in any state other than IDLE SHALL be ignored and SHALL NOT be queued.
REQ-028 start held high continuously SHALL produce back-to-back passes, each separated by exactly one IDLE cycle.
REQ-029 A DRAIN_CYCLES value of 0 SHALL skip DRAIN, going from LOAD directly to COMPUTE.
REQ-030 COMPUTE_CYCLES SHALL be at least 1.
REQ-031 N SHALL be at least 1 and at most 511.

Reset
REQ-032 rst=1 SHALL force, without waiting for a clock edge: state=IDLE, bram_addr=0, bram_data_addr=0, bram_we=0, bram_wdata=0, perceptron_enable=0, busy=0, done=0.
REQ-033 rst asserted mid-pass SHALL abort the pass with no BRAM write, and no done pulse SHALL follow deassertion.
REQ-034 After rst deasserts, the first pass SHALL begin only on a new start in IDLE.

Verification
REQ-035 Defaults, single start pulse -> bram_addr 0..7 on consecutive cycles, perceptron_enable high 4 cycles, one write at address 8, done at cycle 16 after LOAD start.
REQ-036 perceptron_out=16'h1234, fire=1 during COMPUTE -> bram_wdata=32'h0001_1234 with bram_we=1 at address 8 for exactly one cycle.
REQ-037 START_ADDR=9'h1FC, N=8 -> read addresses 1FC,1FD,1FE,1FF,000,001,002,003; write address 004.
REQ-038 start pulsed during LOAD and again during COMPUTE -> exactly one pass and one done pulse.
REQ-039 rst asserted in the third COMPUTE cycle, between clock edges -> all outputs go to 0 immediately, with no bram_we and no done afterwards.
REQ-040 start held high for 40 cycles -> two complete passes, with a single IDLE cycle between done and the next LOAD.
